// File: rtl/quad_decoder.sv
// Quadrature encoder decoder for the front-panel knobs: synchronises and glitch-filters
// A/B, decodes Gray-code steps at x1/x2/x4 and keeps a wrapping or saturating position.
module quad_decoder #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned STEP        = 1,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a,
   input  logic             b,
   input  logic [1:0]       mode,
   input  logic             saturate,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             err_clear,
   output logic [WIDTH-1:0] value,
   output logic             dir,
   output logic             step_pulse,
   output logic             err,
   output logic [3:0]       leds
);

   localparam int unsigned INIT_LEN = SYNC_STAGES + FILTER_LEN;
   localparam int unsigned INIT_W   = $clog2(INIT_LEN + 1);
   localparam int unsigned FLT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   localparam logic [INIT_W-1:0] INIT_VAL = INIT_W'(INIT_LEN);
   localparam logic [FLT_W-1:0]  FLT_LAST = FLT_W'(FILTER_LEN - 1);
   localparam logic [WIDTH:0]    STEP_EXT = (WIDTH + 1)'(STEP);
   localparam logic [WIDTH-1:0]  VAL_MAX  = '1;
   localparam logic [1:0]        MODE_X1  = 2'b00;
   localparam logic [1:0]        MODE_X2  = 2'b01;

   // Channel index 1 is A, index 0 is B throughout.
   logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
   logic [1:0][FLT_W-1:0]       fcnt_q, fcnt_d;
   logic [1:0]                  filt_q, filt_d;
   logic [1:0]                  prev_q, prev_d;
   logic [INIT_W-1:0]           init_q, init_d;
   logic [WIDTH-1:0]            value_q, value_d;
   logic                        dir_q, dir_d;
   logic                        step_q, step_d;
   logic                        err_q, err_d;
   logic [3:0]                  leds_q, leds_d;

   logic [1:0]       raw_c;
   logic [1:0]       sync_out_c;
   logic             init_active_c;
   logic             fwd_c;
   logic             bwd_c;
   logic             illegal_c;
   logic             a_moved_c;
   logic             x1_edge_c;
   logic             mode_sel_c;
   logic             count_en_c;
   logic [WIDTH:0]   sum_c;
   logic [WIDTH:0]   diff_c;
   logic [WIDTH-1:0] count_value_c;

   assign raw_c         = {a, b};
   assign sync_out_c    = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
   assign init_active_c = (init_q != '0);

   // Synchroniser shift, per-channel persistence filter and init countdown.
   always_comb begin
      sync_d = sync_q;
      fcnt_d = fcnt_q;
      filt_d = filt_q;
      init_d = init_q;
      prev_d = filt_q;
      if (init_active_c) begin
         init_d = init_q - INIT_W'(1);
      end
      for (int ch = 0; ch < 2; ch++) begin
         sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], raw_c[ch]};
         if (init_active_c) begin
            filt_d[ch] = sync_out_c[ch];
            fcnt_d[ch] = '0;
         end else if (sync_out_c[ch] == filt_q[ch]) begin
            fcnt_d[ch] = '0;
         end else if (fcnt_q[ch] == FLT_LAST) begin
            filt_d[ch] = sync_out_c[ch];
            fcnt_d[ch] = '0;
         end else begin
            fcnt_d[ch] = fcnt_q[ch] + FLT_W'(1);
         end
      end
   end

   // Gray-code step classification of {prev, cur}; each nibble is {A,B}.
   always_comb begin
      fwd_c     = 1'b0;
      bwd_c     = 1'b0;
      illegal_c = 1'b0;
      case ({prev_q, filt_q})
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd_c     = 1'b1;
         4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: bwd_c     = 1'b1;
         4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: illegal_c = 1'b1;
         default: ;
      endcase
   end

   // Resolution select: x1 counts only the 00<->10 edge, x2 every A edge.
   always_comb begin
      a_moved_c = prev_q[1] ^ filt_q[1];
      x1_edge_c = ({prev_q, filt_q} == 4'b00_10) || ({prev_q, filt_q} == 4'b10_00);
      case (mode)
         MODE_X1: mode_sel_c = x1_edge_c;
         MODE_X2: mode_sel_c = a_moved_c;
         default: mode_sel_c = 1'b1;
      endcase
      count_en_c = !init_active_c && (fwd_c || bwd_c) && mode_sel_c;
   end

   // Up/down arithmetic; the extra MSB flags carry out or borrow for clamping.
   always_comb begin
      sum_c  = {1'b0, value_q} + STEP_EXT;
      diff_c = {1'b0, value_q} - STEP_EXT;
      if (fwd_c) begin
         count_value_c = (sum_c[WIDTH] && saturate) ? VAL_MAX : sum_c[WIDTH-1:0];
      end else begin
         count_value_c = (diff_c[WIDTH] && saturate) ? '0 : diff_c[WIDTH-1:0];
      end
   end

   // Position, direction, strobe, sticky error and LED mirror.
   always_comb begin
      value_d = value_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
      err_d   = err_q;
      leds_d  = value_q[3:0];
      if (!init_active_c && (fwd_c || bwd_c)) begin
         dir_d = fwd_c;
      end
      if (!init_active_c && illegal_c) begin
         err_d = 1'b1;
      end else if (err_clear) begin
         err_d = 1'b0;
      end
      if (load) begin
         value_d = load_value;
      end else if (count_en_c) begin
         value_d = count_value_c;
         step_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '0;
         fcnt_q  <= '0;
         filt_q  <= '0;
         prev_q  <= '0;
         init_q  <= INIT_VAL;
         value_q <= '0;
         dir_q   <= 1'b0;
         step_q  <= 1'b0;
         err_q   <= 1'b0;
         leds_q  <= '0;
      end else begin
         sync_q  <= sync_d;
         fcnt_q  <= fcnt_d;
         filt_q  <= filt_d;
         prev_q  <= prev_d;
         init_q  <= init_d;
         value_q <= value_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
         err_q   <= err_d;
         leds_q  <= leds_d;
      end
   end

   assign value      = value_q;
   assign dir        = dir_q;
   assign step_pulse = step_q;
   assign err        = err_q;
   assign leds       = leds_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: scenario table, hand-timed corner cases and a randomized
// run, all cross-checked each cycle against a behavioural reference model.
module tb_quad_decoder;

   localparam int W    = 8;
   localparam int STEP = 1;
   localparam int SYNC = 2;
   localparam int FILT = 4;
   localparam int MODV = 1 << W;
   localparam int MAXV = MODV - 1;

   logic         clk = 1'b0;
   logic         reset, a, b, saturate, load, err_clear;
   logic [1:0]   mode;
   logic [W-1:0] load_value, value;
   logic         dir, step_pulse, err;
   logic [3:0]   leds;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   quad_decoder #(.WIDTH(W), .STEP(STEP), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .mode(mode), .saturate(saturate),
      .load(load), .load_value(load_value), .err_clear(err_clear),
      .value(value), .dir(dir), .step_pulse(step_pulse), .err(err), .leds(leds)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Position of an {A,B} pair around the forward cycle 00,10,11,01.
   function automatic int gpos(input bit [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic bit [1:0] gray(input int p);
      case (p % 4)
         0:       return 2'b00;
         1:       return 2'b10;
         2:       return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   // ---------------- reference model ----------------
   bit m_sa [SYNC];
   bit m_sb [SYNC];
   bit m_fa, m_fb, m_pa, m_pb;
   bit win_a[$];
   bit win_b[$];
   int m_init, m_val, m_leds;
   bit m_dir, m_step, m_err;

   always @(posedge clk) begin : ref_model
      bit       so_a, so_b, alld, valid, counted;
      bit [1:0] prv, cur;
      int       pp, pc, d, nv;
      if (reset) begin
         for (int i = 0; i < SYNC; i++) begin
            m_sa[i] = 1'b0;
            m_sb[i] = 1'b0;
         end
         m_fa = 0; m_fb = 0; m_pa = 0; m_pb = 0;
         win_a.delete(); win_b.delete();
         m_init = SYNC + FILT;
         m_val = 0; m_leds = 0; m_dir = 0; m_step = 0; m_err = 0;
      end else begin
         so_a   = m_sa[SYNC-1];
         so_b   = m_sb[SYNC-1];
         prv    = {m_pa, m_pb};
         cur    = {m_fa, m_fb};
         m_leds = m_val % 16;
         m_pa   = m_fa;
         m_pb   = m_fb;
         m_step = 0;
         if (m_init > 0) begin
            m_fa = so_a;
            m_fb = so_b;
            win_a.delete(); win_b.delete();
            if (load) m_val = int'(load_value);
            if (err_clear) m_err = 0;
            m_init--;
         end else begin
            pp    = gpos(prv);
            pc    = gpos(cur);
            d     = (pc - pp + 4) % 4;
            valid = (d == 1) || (d == 3);
            case (mode)
               2'b00:   counted = valid && (pp + pc == 1);
               2'b01:   counted = valid && (pp / 2 == pc / 2);
               default: counted = valid;
            endcase
            if (valid) m_dir = (d == 1);
            if (d == 2) m_err = 1;
            else if (err_clear) m_err = 0;
            if (load) begin
               m_val = int'(load_value);
            end else if (counted) begin
               nv = (d == 1) ? m_val + STEP : m_val - STEP;
               if (saturate) nv = (nv > MAXV) ? MAXV : ((nv < 0) ? 0 : nv);
               else          nv = (nv + MODV) % MODV;
               m_val  = nv;
               m_step = 1;
            end
            // A level is accepted after FILT consecutive differing samples.
            win_a.push_back(so_a);
            if (win_a.size() > FILT) void'(win_a.pop_front());
            alld = (win_a.size() == FILT);
            foreach (win_a[k]) if (win_a[k] == m_fa) alld = 0;
            if (alld) begin m_fa = so_a; win_a.delete(); end
            win_b.push_back(so_b);
            if (win_b.size() > FILT) void'(win_b.pop_front());
            alld = (win_b.size() == FILT);
            foreach (win_b[k]) if (win_b[k] == m_fb) alld = 0;
            if (alld) begin m_fb = so_b; win_b.delete(); end
         end
         for (int i = SYNC - 1; i > 0; i--) begin
            m_sa[i] = m_sa[i-1];
            m_sb[i] = m_sb[i-1];
         end
         m_sa[0] = a;
         m_sb[0] = b;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_cmp++;
         if ({value, dir, step_pulse, err, leds} !==
             {W'(m_val), m_dir, m_step, m_err, 4'(m_leds)}) begin
            n_bad++;
            $display("FAIL model t=%0t (dut/model) value=%h/%h dir=%b/%b step=%b/%b err=%b/%b leds=%h/%h",
                     $time, value, W'(m_val), dir, m_dir, step_pulse, m_step, err, m_err, leds, 4'(m_leds));
         end
      end
   end

   // ---------------- directed scenarios ----------------
   typedef struct {
      string        name;
      logic [1:0]   mode;
      logic         sat;
      logic [W-1:0] start;
      int           dirn;
      int           steps;
      logic [W-1:0] exp_val;
      logic         exp_dir;
      int           exp_pulses;
   } row_t;

   row_t rows [10];
   int   pos;
   int   pulses;
   bit   early_ok;

   task automatic hold(input int n);
      repeat (n) begin
         @(negedge clk);
         if (step_pulse === 1'b1) pulses++;
      end
   endtask

   initial begin
      rows[0] = '{"x4_fwd",     2'b10, 1'b0, 8'h00,  1, 8, 8'h08, 1'b1, 8};
      rows[1] = '{"x2_fwd",     2'b01, 1'b0, 8'h00,  1, 8, 8'h04, 1'b1, 4};
      rows[2] = '{"x1_fwd",     2'b00, 1'b0, 8'h00,  1, 8, 8'h02, 1'b1, 2};
      rows[3] = '{"x1_bwd",     2'b00, 1'b0, 8'h02, -1, 8, 8'h00, 1'b0, 2};
      rows[4] = '{"sat_top",    2'b10, 1'b1, 8'hFE,  1, 4, 8'hFF, 1'b1, 4};
      rows[5] = '{"wrap_top",   2'b10, 1'b0, 8'hFE,  1, 4, 8'h02, 1'b1, 4};
      rows[6] = '{"sat_bottom", 2'b10, 1'b1, 8'h00, -1, 4, 8'h00, 1'b0, 4};
      rows[7] = '{"m11_wrap",   2'b11, 1'b0, 8'h01, -1, 4, 8'hFD, 1'b0, 4};
      rows[8] = '{"x2_sat",     2'b01, 1'b1, 8'hFF,  1, 8, 8'hFF, 1'b1, 4};
      rows[9] = '{"x1_wrap",    2'b00, 1'b0, 8'hFF,  1, 4, 8'h00, 1'b1, 1};

      reset = 1; a = 1; b = 1; mode = 2'b10; saturate = 0;
      load = 0; load_value = '0; err_clear = 0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      reset  = 0;

      // Pins resting at 11 through the init window: nothing moves.
      pulses = 0;
      hold(20);
      check("rst11_pulses", pulses, 0);
      check("rst11_value", value, 0);
      check("rst11_err", err, 0);
      check("rst11_dir", dir, 0);

      reset = 1; a = 0; b = 0;
      @(negedge clk);
      reset = 0;
      hold(10);
      pos = 0;

      foreach (rows[i]) begin
         @(negedge clk);
         mode = rows[i].mode; saturate = rows[i].sat;
         load = 1; load_value = rows[i].start;
         @(negedge clk);
         load = 0;
         pulses = 0;
         for (int s = 0; s < rows[i].steps; s++) begin
            pos = (pos + rows[i].dirn + 4) % 4;
            {a, b} = gray(pos);
            hold(10);
         end
         check($sformatf("%s_value", rows[i].name), value, rows[i].exp_val);
         check($sformatf("%s_dir", rows[i].name), dir, rows[i].exp_dir);
         check($sformatf("%s_pulses", rows[i].name), pulses, rows[i].exp_pulses);
      end

      // Pin-to-count latency: SYNC+FILT edges after the first sampling edge.
      @(negedge clk);
      mode = 2'b10; saturate = 0; load = 1; load_value = '0;
      @(negedge clk);
      load = 0;
      hold(2);
      a = 1;
      @(posedge clk);
      early_ok = 1;
      for (int k = 0; k < SYNC + FILT; k++) begin
         @(negedge clk);
         if (value !== 8'h00 || step_pulse !== 1'b0) early_ok = 0;
      end
      @(negedge clk);
      check("lat_no_early", early_ok, 1);
      check("lat_value", value, 8'h01);
      check("lat_pulse", step_pulse, 1);
      hold(4);
      a = 0;
      hold(10);
      check("lat_back_value", value, 8'h00);
      check("lat_back_dir", dir, 0);

      // Short glitch rejected, FILT-long pulse counts up then down.
      pulses = 0;
      a = 1; hold(3); a = 0; hold(12);
      check("glitch3_pulses", pulses, 0);
      check("glitch3_value", value, 8'h00);
      check("glitch3_dir", dir, 0);
      check("glitch3_err", err, 0);
      pulses = 0;
      a = 1; hold(4); a = 0; hold(16);
      check("pulse4_pulses", pulses, 2);
      check("pulse4_value", value, 8'h00);
      check("pulse4_dir", dir, 0);

      // Illegal jumps; set beats a coincident clear.
      a = 1; b = 1; hold(10);
      check("illegal_err", err, 1);
      check("illegal_value", value, 8'h00);
      a = 0; b = 0;
      repeat (SYNC + FILT) @(posedge clk);
      @(negedge clk);
      err_clear = 1;
      @(negedge clk);
      err_clear = 0;
      check("illegal_vs_clear_err", err, 1);
      hold(4);
      err_clear = 1;
      @(negedge clk);
      err_clear = 0;
      check("clear_err", err, 0);

      // Load on the same edge as a counted step.
      hold(2);
      a = 1;
      repeat (SYNC + FILT) @(posedge clk);
      @(negedge clk);
      load = 1; load_value = 8'h55;
      @(negedge clk);
      load = 0;
      check("load_vs_step_value", value, 8'h55);
      check("load_vs_step_pulse", step_pulse, 0);
      check("load_vs_step_dir", dir, 1);
      hold(6);
      a = 0;
      hold(10);
      check("after_load_value", value, 8'h54);

      // Reset in mid-operation.
      reset = 1;
      @(negedge clk);
      reset = 0;
      check("midrst_value", value, 8'h00);
      check("midrst_leds", leds, 4'h0);
      check("midrst_dir", dir, 0);
      hold(10);

      // Randomized pins (incl. glitches and illegal jumps) and controls.
      for (int seg = 0; seg < 400; seg++) begin
         a        = 1'($urandom_range(0, 1));
         b        = 1'($urandom_range(0, 1));
         mode     = 2'($urandom_range(0, 3));
         saturate = 1'($urandom_range(0, 1));
         for (int c = 0; c < int'($urandom_range(1, 12)); c++) begin
            load       = ($urandom_range(0, 11) == 0);
            load_value = W'($urandom);
            err_clear  = ($urandom_range(0, 9) == 0);
            reset      = ($urandom_range(0, 299) == 0);
            @(negedge clk);
         end
      end
      load = 0; err_clear = 0; reset = 0;
      hold(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
Parametrised quadrature encoder decoder for the front-panel knobs.
- Synchronises the raw A/B pins and glitch-filters each channel.
- Decodes Gray-code transitions in x1, x2 or x4 resolution.
- Maintains a WIDTH-bit position counter with selectable wrap or saturate.
- Also provides: synchronous preload, direction flag, a per-count strobe, sticky illegal-transition error, and a registered LED mirror of value[3:0].
- Sits between the encoder pins and the pulser configuration registers.

Parameters:
WIDTH, 8, counter width in bits (>=4)
STEP, 1, amount added or subtracted per counted transition (1 <= STEP < 2^WIDTH)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILTER_LEN, 4, consecutive cycles a synchronised level must differ from the filtered level before it is accepted (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
a  in  1  raw encoder channel A (asynchronous)
b  in  1  raw encoder channel B (asynchronous)
mode  in  2  00=x1, 01=x2, 10=x4, 11=x4 (reserved)
saturate  in  1  0=wrap modulo 2^WIDTH, 1=clamp at 0 and 2^WIDTH-1
load  in  1  synchronous preload strobe
load_value  in  WIDTH  value written on load
err_clear  in  1  clears err
value  out  WIDTH  position counter
dir  out  1  last valid direction (1=forward, 0=backward)
step_pulse  out  1  one-cycle strobe per counted transition
err  out  1  sticky illegal-transition flag
leds  out  4  value[3:0] delayed one cycle

Behaviour:
- Reset values:
  - value=0, dir=0, step_pulse=0, err=0, leds=0.
  - Synchroniser flops, filter counters, filtered state and previous state all 0.
  - Init counter loaded with SYNC_STAGES+FILTER_LEN.
- Init window (init counter nonzero, decremented each cycle):
  - Filtered A/B copy the synchroniser outputs directly, and the previous state copies the filtered state.
  - No counting, no err, step_pulse=0. load is still honoured.
  - Ensures pins resting at 11 after reset produce no count and no error.
- Synchroniser: SYNC_STAGES-deep shift per channel.
- Filter, per channel:
  - Counter increments while sync != filtered and clears to 0 when they are equal.
  - When the counter reaches FILTER_LEN-1 and the mismatch persists, filtered takes the sync value and the counter clears.
  - Pulses shorter than FILTER_LEN cycles are ignored.
- Latency: an input level stable from before edge N changes value at edge N+SYNC_STAGES+FILTER_LEN (6 with defaults). step_pulse is high in the cycle value shows the new count.
- Decode compares prev={A,B} with cur={A,B} each cycle; prev<=cur every cycle.
  - Forward sequence: 00->10->11->01->00.
  - Backward sequence: the reverse.
  - prev==cur: no action.
  - Both bits changed (00<->11, 10<->01): illegal; err<=1, no count, dir unchanged.
- Counted transitions by mode:
  - x4: every valid transition.
  - x2: only transitions where A changes.
  - x1: forward 00->10 and backward 10->00 only.
  - dir updates on every valid transition regardless of mode.
- Arithmetic:
  - Forward: value+STEP. Backward: value-STEP.
  - saturate=0: wraps modulo 2^WIDTH.
  - saturate=1: clamps to 2^WIDTH-1 on overflow and to 0 on underflow, with no wrap. step_pulse still asserts when clamped.
  - Overflow detected using a WIDTH+1-bit sum.
- load: value<=load_value next edge and takes priority over a same-cycle count. That transition's step_pulse is suppressed; dir and err still update.
- err: set has priority over err_clear in the same cycle.
- mode and saturate are sampled every cycle; a change affects only later transitions and never alters value by itself.
- leds<=value[3:0] each cycle (one-cycle lag).
- Reset asserted mid-operation: all state returns to reset values on that edge, and the init window restarts.

Test Plan:
- Reset with a=b=1 held for 20 cycles -> value=0, err=0, step_pulse never high.
- mode=10, STEP=1, two full forward cycles (AB 00,10,11,01,00 x2, each step held 10 cycles) -> value=8, dir=1, 8 step_pulses; first update exactly 6 edges after the first A edge.
- Same stimulus with mode=01 -> value=4; with mode=00 -> value=2; reverse sequence with mode=00 from value=2 -> value=0, dir=0.
- saturate=1, load 8'hFE, 4 forward x4 steps -> value=8'hFF, 4 step_pulses; saturate=0 from 8'hFE -> value=8'h02; backward from 0 with saturate=1 -> stays 0.
- 3-cycle glitch on A (FILTER_LEN=4) -> no change to value, dir, err; a 4-cycle pulse -> one count up then one count down.
- AB jump 00->11 held -> err=1 and value unchanged; err_clear coincident with a second illegal jump -> err stays 1; err_clear alone -> err=0; load coincident with a valid step -> value=load_value, no step_pulse.
